regfile_2r1w: RTL

//  Parametrised multi-port register file for the datapath: NUM_REGS x WIDTH storage,
//  two asynchronous read ports, one clocked write port with per-register write enable.

---
 rtl/regfile_2r1w.sv | 121 ++++++++++++
 1 files changed

// File: rtl/regfile_2r1w.sv
// NUM_REGS x WIDTH register file: two combinational read ports, one clocked write port,
// hardwired zero register, optional write-to-read forwarding and a sequenced clear sweep.
module regfile_2r1w #(
   parameter int unsigned WIDTH    = 64,
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned ZERO_REG = 31,
   parameter bit          BYPASS   = 1'b1,
   parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [WIDTH-1:0]  rd_data_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [WIDTH-1:0]  rd_data_b,
   input  logic              clr_req,
   output logic              busy
);

   typedef enum logic [0:0] {StIdle, StSweep} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0]  regs_q [NUM_REGS];
   logic [NUM_REGS-1:0] wr_sel, clr_sel;
   logic              wr_fire;
   logic              byp_a, byp_b;

   assign busy = (state_q == StSweep);

   // A write is only accepted outside a sweep and to a real, non-zero register.
   assign wr_fire = wr_en && !busy && (32'(wr_addr) < NUM_REGS) && (32'(wr_addr) != ZERO_REG);

   assign byp_a = BYPASS && wr_fire && (wr_addr == rd_addr_a);
   assign byp_b = BYPASS && wr_fire && (wr_addr == rd_addr_b);

   always_comb begin
      wr_sel  = '0;
      clr_sel = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         wr_sel[i]  = wr_fire && (wr_addr == ADDR_W'(i));
         clr_sel[i] = busy && (idx_q == ADDR_W'(i));
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         StIdle: begin
            if (clr_req) begin
               state_d = StSweep;
               idx_d   = '0;
            end
         end
         StSweep: begin
            // clr_req is ignored here; the sweep always runs to completion.
            if (idx_q == ADDR_W'(NUM_REGS - 1)) begin
               state_d = StIdle;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (clr_sel[i]) begin
               regs_q[i] <= '0;
            end else if (wr_sel[i]) begin
               regs_q[i] <= wr_data;
            end
         end
      end
   end

   // Out-of-range and zero-register addresses match no entry and read as zero.
   always_comb begin
      rd_data_a = '0;
      rd_data_b = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (i != ZERO_REG && rd_addr_a == ADDR_W'(i)) begin
            rd_data_a = regs_q[i];
         end
         if (i != ZERO_REG && rd_addr_b == ADDR_W'(i)) begin
            rd_data_b = regs_q[i];
         end
      end
      if (byp_a) begin
         rd_data_a = wr_data;
      end
      if (byp_b) begin
         rd_data_b = wr_data;
      end
   end

endmodule
